// File: rtl/fc_feeder_pkg.sv
// Shared CNN definitions: operand/result width, FC fan-in and the feeder FSM encoding.
// Used by fc_feeder and by the fc_layer that consumes its operand vector.
// Pure declarations, no logic.
package fc_feeder_pkg;

   localparam int DATA_W     = 32;
   localparam int FC_N_IN    = 9;
   localparam int FC_TIMEOUT = 64;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } fc_state_t;

endpackage

// File: rtl/fc_feeder_if.sv
// Bundle of the feeder's operand stream, FC-layer handshake and result handshake.
// slave  = fc_feeder side (drives in_ready, fc_input, fc_enable, res_*, err).
// master = environment side (drives operands, FC-layer completion, res_ready).
interface fc_feeder_if #(
   parameter int N_IN   = fc_feeder_pkg::FC_N_IN,
   parameter int DATA_W = fc_feeder_pkg::DATA_W
);

   logic                     in_valid;
   logic signed [DATA_W-1:0] in_data;
   logic                     in_ready;

   logic signed [DATA_W-1:0] fc_input [0:N_IN-1];
   logic                     fc_enable;
   logic                     fc_done;
   logic signed [DATA_W-1:0] fc_result;

   logic                     res_valid;
   logic signed [DATA_W-1:0] res_data;
   logic                     res_ready;
   logic                     err;

   modport master (
      output in_valid, in_data, fc_done, fc_result, res_ready,
      input  in_ready, fc_input, fc_enable, res_valid, res_data, err
   );

   modport slave (
      input  in_valid, in_data, fc_done, fc_result, res_ready,
      output in_ready, fc_input, fc_enable, res_valid, res_data, err
   );

endinterface

// File: rtl/fc_feeder.sv
// Gathers N_IN operands, pulses the FC layer, captures its result (or aborts after TIMEOUT cycles).
// Ports: clk, rst (sync, active-high), bus (fc_feeder_if.slave). Latency: last accept t -> fc_enable t+1; fc_done d -> res_valid d+1.
// Backpressure: in_ready only in FILL; result held in HOLD until res_ready; err is sticky until rst.
module fc_feeder #(
   parameter int N_IN    = fc_feeder_pkg::FC_N_IN,
   parameter int DATA_W  = fc_feeder_pkg::DATA_W,
   parameter int TIMEOUT = fc_feeder_pkg::FC_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst,
   fc_feeder_if.slave bus
);

   import fc_feeder_pkg::*;

   localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int TCNT_W = $clog2(TIMEOUT + 1);

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_IN - 1);
   // WAIT lasts at most TIMEOUT cycles: counter values 0 .. TIMEOUT-1.
   localparam logic [TCNT_W-1:0] LAST_TICK = TCNT_W'(TIMEOUT - 1);

   fc_state_t                state;
   logic [IDX_W-1:0]         idx;
   logic [TCNT_W-1:0]        tcnt;
   logic signed [DATA_W-1:0] opbuf [0:N_IN-1];
   logic                     fc_enable_q;
   logic                     res_valid_q;
   logic signed [DATA_W-1:0] res_data_q;
   logic                     err_q;
   logic                     accept;

   // in_ready is the only combinational output.
   assign bus.in_ready = (state == FILL);
   assign accept       = bus.in_valid && (state == FILL);

   assign bus.fc_enable = fc_enable_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.err       = err_q;

   // The buffer is only written in FILL, so the FC layer sees a stable vector
   // from ISSUE until the result is released.
   for (genvar g = 0; g < N_IN; g++) begin : g_fc_input
      assign bus.fc_input[g] = opbuf[g];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FILL;
         idx         <= '0;
         tcnt        <= '0;
         fc_enable_q <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i < N_IN; i++) begin
            opbuf[i] <= '0;
         end
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  opbuf[idx] <= bus.in_data;
                  if (idx == LAST_IDX) begin
                     idx         <= '0;
                     fc_enable_q <= 1'b1;
                     state       <= ISSUE;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end

            ISSUE: begin
               fc_enable_q <= 1'b0;
               tcnt        <= '0;
               state       <= WAIT;
            end

            // fc_done is only honoured here; elsewhere it is a don't-care.
            WAIT: begin
               if (bus.fc_done) begin
                  res_data_q  <= bus.fc_result;
                  res_valid_q <= 1'b1;
                  state       <= HOLD;
               end else if (tcnt == LAST_TICK) begin
                  res_data_q  <= '0;
                  res_valid_q <= 1'b1;
                  err_q       <= 1'b1;
                  state       <= HOLD;
               end else begin
                  tcnt <= tcnt + TCNT_W'(1);
               end
            end

            HOLD: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state       <= FILL;
               end
            end

            default: begin
               state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc_feeder.sv
module tb_fc_feeder;

   localparam int NI = 9;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fc_feeder_if #(.N_IN(NI), .DATA_W(DW)) bus ();

   fc_feeder #(.N_IN(NI), .DATA_W(DW), .TIMEOUT(64)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int vectors     = 0;
   int miscompares = 0;
   int enable_cnt  = 0;

   logic signed [DW-1:0] exp_op_q  [$];
   logic signed [DW-1:0] exp_res_q [$];

   always @(posedge clk) begin
      if (!rst && bus.fc_enable === 1'b1) enable_cnt++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input int n);
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.fc_done   = 1'b0;
      bus.fc_result = '0;
      bus.res_ready = 1'b0;
      repeat (n) cycle();
      rst = 1'b0;
      exp_op_q.delete();
      exp_res_q.delete();
   endtask

   // Drives count operands base, base+1, ... ; returns just after the last accept edge.
   task automatic feed(input int base, input int count, input bit gapped);
      for (int k = 0; k < count; k++) begin
         bit taken;
         int guard;
         taken = 1'b0;
         guard = 0;
         bus.in_valid = 1'b1;
         bus.in_data  = DW'(base + k);
         exp_op_q.push_back(DW'(base + k));
         while (!taken && guard < 200) begin
            taken = bus.in_ready;
            cycle();
            guard++;
         end
         if (!taken) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout op %0d: in_ready=%b, required 1", k, bus.in_ready);
         end
         bus.in_valid = 1'b0;
         if (gapped && k != count - 1) cycle();
      end
   endtask

   task automatic test_reset();
      apply_reset(2);
      vectors++; if (bus.in_ready  !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
      vectors++; if (bus.fc_enable !== 1'b0) begin miscompares++; $display("FAIL rst_fc_enable got %b exp 0", bus.fc_enable); end
      vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_res_valid got %b exp 0", bus.res_valid); end
      vectors++; if (bus.res_data  !== '0)   begin miscompares++; $display("FAIL rst_res_data got %0d exp 0", bus.res_data); end
      vectors++; if (bus.err       !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b exp 0", bus.err); end
      for (int k = 0; k < NI; k++) begin
         vectors++;
         if (bus.fc_input[k] !== '0) begin miscompares++; $display("FAIL rst_fc_input[%0d] got %0d exp 0", k, bus.fc_input[k]); end
      end
   endtask

   task automatic test_stream();
      int en0;
      logic signed [DW-1:0] r;
      en0 = enable_cnt;
      feed(1, 9, 1'b0);
      vectors++; if (bus.fc_enable !== 1'b1) begin miscompares++; $display("FAIL stream_enable_latency got %b exp 1", bus.fc_enable); end
      vectors++; if (bus.in_ready  !== 1'b0) begin miscompares++; $display("FAIL stream_in_ready_issue got %b exp 0", bus.in_ready); end
      for (int k = 0; k < NI; k++) begin
         logic signed [DW-1:0] e;
         e = exp_op_q.pop_front();
         vectors++;
         if (bus.fc_input[k] !== e) begin miscompares++; $display("FAIL stream_fc_input[%0d] got %0d exp %0d", k, bus.fc_input[k], e); end
      end
      cycle();
      vectors++; if (bus.fc_enable !== 1'b0) begin miscompares++; $display("FAIL stream_enable_pulse got %b exp 0", bus.fc_enable); end
      cycle();
      cycle();
      bus.fc_done   = 1'b1;
      bus.fc_result = -285;
      exp_res_q.push_back(-285);
      cycle();
      bus.fc_done = 1'b0;
      r = exp_res_q.pop_front();
      for (int c = 0; c < 5; c++) begin
         vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL stream_res_valid_hold c%0d got %b exp 1", c, bus.res_valid); end
         vectors++; if (bus.res_data  !== r)    begin miscompares++; $display("FAIL stream_res_data_hold c%0d got %0d exp %0d", c, bus.res_data, r); end
         vectors++; if (bus.in_ready  !== 1'b0) begin miscompares++; $display("FAIL stream_in_ready_hold c%0d got %b exp 0", c, bus.in_ready); end
         cycle();
      end
      bus.res_ready = 1'b1;
      cycle();
      bus.res_ready = 1'b0;
      vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL stream_release_valid got %b exp 0", bus.res_valid); end
      vectors++; if (bus.in_ready  !== 1'b1) begin miscompares++; $display("FAIL stream_release_ready got %b exp 1", bus.in_ready); end
      vectors++; if (enable_cnt - en0 !== 1) begin miscompares++; $display("FAIL stream_enable_count got %0d exp 1", enable_cnt - en0); end
   endtask

   task automatic test_gapped();
      logic signed [DW-1:0] exp_vec [NI];
      logic signed [DW-1:0] r;
      feed(1, 9, 1'b1);
      vectors++; if (bus.fc_enable !== 1'b1) begin miscompares++; $display("FAIL gap_enable got %b exp 1", bus.fc_enable); end
      for (int k = 0; k < NI; k++) begin
         exp_vec[k] = exp_op_q.pop_front();
         vectors++;
         if (bus.fc_input[k] !== exp_vec[k]) begin miscompares++; $display("FAIL gap_fc_input[%0d] got %0d exp %0d", k, bus.fc_input[k], exp_vec[k]); end
      end
      // Junk operand offered and res_ready raised while no result is pending.
      bus.in_valid  = 1'b1;
      bus.in_data   = -1;
      bus.res_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cycle();
         vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL gap_in_ready_wait c%0d got %b exp 0", c, bus.in_ready); end
         vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL gap_res_valid_wait c%0d got %b exp 0", c, bus.res_valid); end
      end
      bus.fc_done   = 1'b1;
      bus.fc_result = 32'sh7FFF_FFFF;
      exp_res_q.push_back(32'sh7FFF_FFFF);
      cycle();
      bus.fc_done = 1'b0;
      r = exp_res_q.pop_front();
      vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL gap_res_valid got %b exp 1", bus.res_valid); end
      vectors++; if (bus.res_data  !== r)    begin miscompares++; $display("FAIL gap_res_data got %0d exp %0d", bus.res_data, r); end
      vectors++; if (bus.in_ready  !== 1'b0) begin miscompares++; $display("FAIL gap_in_ready_hold got %b exp 0", bus.in_ready); end
      for (int k = 0; k < NI; k++) begin
         vectors++;
         if (bus.fc_input[k] !== exp_vec[k]) begin miscompares++; $display("FAIL gap_stable[%0d] got %0d exp %0d", k, bus.fc_input[k], exp_vec[k]); end
      end
      bus.in_valid = 1'b0;
      cycle();
      bus.res_ready = 1'b0;
      vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL gap_release got %b exp 0", bus.res_valid); end
   endtask

   task automatic test_timeout();
      int n;
      logic signed [DW-1:0] r;
      feed(20, 9, 1'b0);
      for (int k = 0; k < NI; k++) begin
         logic signed [DW-1:0] e;
         e = exp_op_q.pop_front();
         vectors++;
         if (bus.fc_input[k] !== e) begin miscompares++; $display("FAIL to_fc_input[%0d] got %0d exp %0d", k, bus.fc_input[k], e); end
      end
      exp_res_q.push_back('0);
      n = 0;
      while (bus.res_valid !== 1'b1 && n < 200) begin cycle(); n++; end
      r = exp_res_q.pop_front();
      vectors++; if (n !== 65)              begin miscompares++; $display("FAIL to_cycles got %0d exp 65", n); end
      vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL to_res_valid got %b exp 1", bus.res_valid); end
      vectors++; if (bus.res_data  !== r)    begin miscompares++; $display("FAIL to_res_data got %0d exp %0d", bus.res_data, r); end
      vectors++; if (bus.err       !== 1'b1) begin miscompares++; $display("FAIL to_err got %b exp 1", bus.err); end
      bus.res_ready = 1'b1;
      cycle();
      bus.res_ready = 1'b0;
      feed(30, 9, 1'b0);
      for (int k = 0; k < NI; k++) begin
         logic signed [DW-1:0] e;
         e = exp_op_q.pop_front();
         vectors++;
         if (bus.fc_input[k] !== e) begin miscompares++; $display("FAIL to_next_fc_input[%0d] got %0d exp %0d", k, bus.fc_input[k], e); end
      end
      cycle();
      bus.fc_done   = 1'b1;
      bus.fc_result = 12345;
      exp_res_q.push_back(12345);
      cycle();
      bus.fc_done = 1'b0;
      r = exp_res_q.pop_front();
      vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL to_next_valid got %b exp 1", bus.res_valid); end
      vectors++; if (bus.res_data  !== r)    begin miscompares++; $display("FAIL to_next_data got %0d exp %0d", bus.res_data, r); end
      vectors++; if (bus.err       !== 1'b1) begin miscompares++; $display("FAIL to_err_sticky got %b exp 1", bus.err); end
      bus.res_ready = 1'b1;
      cycle();
      bus.res_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int en0;
      logic signed [DW-1:0] r;
      apply_reset(1);
      vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL rm_err_cleared got %b exp 0", bus.err); end
      feed(40, 5, 1'b0);
      apply_reset(1);
      vectors++; if (bus.in_ready    !== 1'b1) begin miscompares++; $display("FAIL rm_in_ready got %b exp 1", bus.in_ready); end
      vectors++; if (bus.fc_input[0] !== '0)   begin miscompares++; $display("FAIL rm_buf_cleared got %0d exp 0", bus.fc_input[0]); end
      en0 = enable_cnt;
      for (int c = 0; c < 3; c++) begin
         vectors++; if (bus.fc_enable !== 1'b0) begin miscompares++; $display("FAIL rm_no_enable c%0d got %b exp 0", c, bus.fc_enable); end
         cycle();
      end
      feed(10, 9, 1'b0);
      for (int k = 0; k < NI; k++) begin
         logic signed [DW-1:0] e;
         e = exp_op_q.pop_front();
         vectors++;
         if (bus.fc_input[k] !== e) begin miscompares++; $display("FAIL rm_fc_input[%0d] got %0d exp %0d", k, bus.fc_input[k], e); end
      end
      cycle();
      cycle();
      bus.fc_done   = 1'b1;
      bus.fc_result = -1;
      exp_res_q.push_back(-1);
      cycle();
      bus.fc_done = 1'b0;
      r = exp_res_q.pop_front();
      vectors++; if (bus.res_data !== r) begin miscompares++; $display("FAIL rm_res_data got %0d exp %0d", bus.res_data, r); end
      bus.res_ready = 1'b1;
      cycle();
      bus.res_ready = 1'b0;
      vectors++; if (enable_cnt - en0 !== 1) begin miscompares++; $display("FAIL rm_enable_count got %0d exp 1", enable_cnt - en0); end
   endtask

   task automatic test_done_in_fill();
      logic signed [DW-1:0] r;
      bus.fc_done   = 1'b1;
      bus.fc_result = 777;
      for (int c = 0; c < 3; c++) begin
         cycle();
         vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL dif_res_valid c%0d got %b exp 0", c, bus.res_valid); end
         vectors++; if (bus.in_ready  !== 1'b1) begin miscompares++; $display("FAIL dif_in_ready c%0d got %b exp 1", c, bus.in_ready); end
      end
      bus.fc_done = 1'b0;
      feed(50, 4, 1'b0);
      bus.fc_done = 1'b1;
      cycle();
      bus.fc_done = 1'b0;
      vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL dif_mid_valid got %b exp 0", bus.res_valid); end
      vectors++; if (bus.in_ready  !== 1'b1) begin miscompares++; $display("FAIL dif_mid_ready got %b exp 1", bus.in_ready); end
      feed(54, 5, 1'b0);
      vectors++; if (bus.fc_enable !== 1'b1) begin miscompares++; $display("FAIL dif_enable got %b exp 1", bus.fc_enable); end
      for (int k = 0; k < NI; k++) begin
         logic signed [DW-1:0] e;
         e = exp_op_q.pop_front();
         vectors++;
         if (bus.fc_input[k] !== e) begin miscompares++; $display("FAIL dif_fc_input[%0d] got %0d exp %0d", k, bus.fc_input[k], e); end
      end
      cycle();
      bus.fc_done   = 1'b1;
      bus.fc_result = -99;
      exp_res_q.push_back(-99);
      cycle();
      bus.fc_done = 1'b0;
      r = exp_res_q.pop_front();
      vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL dif_final_valid got %b exp 1", bus.res_valid); end
      vectors++; if (bus.res_data  !== r)    begin miscompares++; $display("FAIL dif_final_data got %0d exp %0d", bus.res_data, r); end
      bus.res_ready = 1'b1;
      cycle();
      bus.res_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_gapped();
      test_timeout();
      test_reset_mid();
      test_done_in_fill();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fc_feeder.md
FC_FEEDER -- requirements
Module: fc_feeder

Interface
REQ-001 Parameter N_IN, default 9, number of operands gathered per FC evaluation.
REQ-002 Parameter DATA_W, default 32, signed operand and result width.
REQ-003 Parameter TIMEOUT, default 64, maximum cycles in WAIT before abort.
REQ-004 clk  in  1  sole clock; all logic on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  upstream operand valid.
REQ-007 in_data  in  DATA_W signed  upstream operand.
REQ-008 in_ready  out  1  feeder accepting operands.
REQ-009 fc_input  out  DATA_W signed x N_IN (unpacked [0:N_IN-1])  operand vector to FC layer.
REQ-010 fc_enable  out  1  FC layer start pulse.
REQ-011 fc_done  in  1  FC layer completion.
REQ-012 fc_result  in  DATA_W signed  FC layer result, valid with fc_done.
REQ-013 res_valid  out  1  result available downstream.
REQ-014 res_data  out  DATA_W signed  captured result.
REQ-015 res_ready  in  1  downstream accepts result.
REQ-016 err  out  1  sticky timeout flag.

Function
REQ-017 FSM states FILL, ISSUE, WAIT, HOLD; all outputs registered except in_ready.
REQ-018 in_ready SHALL equal (state==FILL); operand accepted on cycle with in_valid && in_ready.
REQ-019 Accepted operand k (k=0..N_IN-1, arrival order) SHALL be written to buffer entry k; index counter increments per accept.
REQ-020 Accept of entry N_IN-1 SHALL move FILL->ISSUE next cycle and reset index to 0.
REQ-021 ISSUE: fc_enable high exactly one cycle, then ISSUE->WAIT unconditionally.
REQ-022 fc_input SHALL drive the buffer continuously; buffer written only in FILL, hence stable from ISSUE through HOLD.
REQ-023 fc_done SHALL be ignored in all states except WAIT.
REQ-024 WAIT with fc_done=1: capture fc_result into res_data, assert res_valid next cycle, WAIT->HOLD.
REQ-025 WAIT timeout counter starts at 0 on entry; if TIMEOUT cycles elapse without fc_done: res_data<=0, err<=1, res_valid<=1, WAIT->HOLD.
REQ-026 HOLD: res_valid and res_data held until res_ready=1; on that cycle res_valid<=0, HOLD->FILL.
REQ-027 res_ready while res_valid=0 SHALL have no effect.
REQ-028 Latency: last operand accepted in cycle t -> fc_enable high in t+1; fc_done in cycle d -> res_valid high in d+1.
REQ-029 Throughput: no operand accepted outside FILL; back-to-back frames separated by at least ISSUE+WAIT+HOLD cycles.
REQ-030 err SHALL remain 1 until rst; subsequent frames operate normally.
REQ-031 No arithmetic performed; res_data equals fc_result bit-exact.

Reset
REQ-032 rst=1 at posedge: state FILL, index 0, timeout counter 0, all buffer entries 0, fc_enable 0, res_valid 0, res_data 0, err 0.
REQ-033 rst mid-frame (any state) SHALL discard partial operands and pending result; no fc_enable pulse after rst deasserts until a full new frame is accepted.
REQ-034 rst takes priority over every simultaneous event including fc_done and res_ready.

Structure
REQ-035 DATA_W, FC_N_IN and the FSM state enum SHALL live in the shared CNN package, reused by fc_layer.
REQ-036 Single module; no sub-module; timeout counter width clog2(TIMEOUT+1).

Verification
REQ-037 Stream 1..9 with in_valid continuous -> fc_input[0..8]=1..9, one fc_enable pulse cycle after 9th accept.
REQ-038 Model FC returning fc_done 3 cycles after enable with fc_result=-285 -> res_valid 1 cycle after done, res_data=-285, held while res_ready=0 for 5 cycles.
REQ-039 Gapped in_valid (every other cycle) -> same buffer contents, in_ready low throughout ISSUE/WAIT/HOLD.
REQ-040 No fc_done for 64 cycles -> err=1, res_valid=1, res_data=0; next frame completes normally with err still 1.
REQ-041 rst after 5 operands, then 9 operands 10..18 -> fc_input=10..18, exactly one fc_enable.
REQ-042 fc_done pulsed during FILL -> no res_valid, no state change.
